// File: rtl/btn_debounce.sv
// Push-button conditioning: two-flop synchronizer per channel followed by an
// independent counter-based debounce FSM. Produces a clean registered level
// per button plus one-clock rise/fall ticks on each accepted transition.
//
// The per-channel FSM state is held in state_q[] so it can be observed
// hierarchically. Values: ZERO=0, WAIT1=1, ONE=2, WAIT0=3.
module btn_debounce #(
    parameter int N_BTN     = 2,
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    // Last count value before a level change is accepted; the counter never
    // exceeds it because every WAIT entry reloads it with zero.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;
    state_t           state_q [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];

    // Two-flop synchronizer bringing the asynchronous button levels into clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Per-channel debounce FSM with registered level and tick outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db   <= '0;
            btn_rise <= '0;
            btn_fall <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= ZERO;
                cnt_q[i]   <= '0;
            end
        end else begin
            // Ticks are single-cycle: cleared unless a transition fires below.
            btn_rise <= '0;
            btn_fall <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                case (state_q[i])
                    ZERO: begin
                        if (s2[i]) begin
                            state_q[i] <= WAIT1;
                            cnt_q[i]   <= '0;
                        end
                    end
                    WAIT1: begin
                        if (!s2[i]) begin
                            // Bounce: input dropped before it was stable long enough.
                            state_q[i] <= ZERO;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_q[i]  <= ONE;
                            btn_db[i]   <= 1'b1;
                            btn_rise[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                    ONE: begin
                        if (!s2[i]) begin
                            state_q[i] <= WAIT0;
                            cnt_q[i]   <= '0;
                        end
                    end
                    WAIT0: begin
                        if (s2[i]) begin
                            // Release glitch: button came back before the count finished.
                            state_q[i] <= ONE;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_q[i]  <= ZERO;
                            btn_db[i]   <= 1'b0;
                            btn_fall[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_q[i] <= ZERO;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input conditioning stage directly upstream of the Pong graph/animation block.
- Takes raw, asynchronous, bouncy push-button levels, synchronizes them to clk, and debounces each channel with an independent counter FSM.
- Outputs a clean level per button, which drives the animation block's btn bus, plus one-cycle rise and fall ticks for game-control use (serve, pause).

Parameters:
- N_BTN, 2, number of independent button channels.
- DB_CYCLES, 1_000_000, stable-input clock cycles required to accept a level change (10 ms at 100 MHz). Must be >= 2.
- CNT_W, 20, counter width. Requirement: 2^CNT_W >= DB_CYCLES.

Ports:
- clk  input  1  system clock. All logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  raw button levels; asynchronous to clk, may bounce.
- btn_db  output  N_BTN  debounced level per channel, registered.
- btn_rise  output  N_BTN  one-clock pulse when a channel's debounced level goes 0->1.
- btn_fall  output  N_BTN  one-clock pulse when a channel's debounced level goes 1->0.

Behaviour:
- One clock, one synchronous active-high reset.
- Synchronizer: per channel, two flops (s1 <= btn_raw, s2 <= s1). The FSM sees only s2.
- Per-channel FSM states: ZERO, WAIT1, ONE, WAIT0. Each channel has its own CNT_W counter.
- ZERO:
  - s2=1: go to WAIT1, cnt <= 0.
  - otherwise stay.
- WAIT1:
  - s2=0: go to ZERO (bounce abort, no tick).
  - s2=1 and cnt==DB_CYCLES-1: go to ONE, btn_db <= 1, btn_rise <= 1.
  - otherwise cnt <= cnt+1.
- ONE:
  - s2=0: go to WAIT0, cnt <= 0.
  - otherwise stay.
- WAIT0:
  - s2=1: go to ONE (abort, no tick).
  - s2=0 and cnt==DB_CYCLES-1: go to ZERO, btn_db <= 0, btn_fall <= 1.
  - otherwise cnt <= cnt+1.
- btn_db is 1 in ONE and WAIT0 and 0 in ZERO and WAIT1. It is registered, with no combinational path from btn_raw.
- btn_rise and btn_fall are registered and high for exactly one clock per accepted transition. They default to 0 every cycle. Rise and fall are never both high on the same channel.
- Latency: number edges so that edge 1 is the first to sample btn_raw=1 into s1, with raw held stable. btn_db and btn_rise go high at edge DB_CYCLES+3. Release latency is identical.
- Glitch rejection:
  - Any synchronized pulse or gap shorter than DB_CYCLES cycles produces no output change.
  - Each abort restarts the count from 0 on the next qualifying edge.
- Channels are fully independent. Simultaneous presses on both channels produce simultaneous ticks when their timing matches.
- Counter is reloaded on every WAIT entry and never wraps: the maximum value reached is DB_CYCLES-1.
- Reset:
  - Values: s1, s2, cnt = 0; state = ZERO; btn_db, btn_rise, btn_fall = 0.
  - rst asserted mid-WAIT1/WAIT0 or in ONE: all of the above on the next edge, with no tick emitted.
  - After rst deasserts with btn_raw held 1: a full press sequence follows, with rise at edge DB_CYCLES+3 counted from the first post-reset edge.

Test Plan (DB_CYCLES=8, CNT_W=4):
- Clean press: after reset, btn_raw=2'b01 held.
  - btn_db[0]=1 and btn_rise[0]=1 at edge 11.
  - btn_rise[0]=0 at edge 12 onward.
  - btn_db[1] stays 0.
- Bounce reject: btn_raw[0] toggles 1,0,1,0 with 3-cycle phases, then holds 1.
  - No rise during the bounce.
  - btn_rise[0] asserts 10 edges after the final 0->1 sample.
- Release: from ONE, btn_raw[0]=0 held.
  - btn_db[0]=0 and btn_fall[0]=1 at edge 11.
  - A 5-cycle 0 glitch instead produces no fall and btn_db stays 1.
- Simultaneous: btn_raw 2'b00->2'b11 on the same cycle.
  - btn_rise=2'b11 on the same cycle (edge 11).
  - btn_db=2'b11.
- Reset mid-operation: assert rst for 1 cycle while channel 0 is in WAIT1 with cnt=5.
  - Next edge: all outputs 0, state ZERO.
  - With raw still 1, rise occurs 11 edges after rst deasserts.
- Long hold: btn_raw=2'b10 held 100 cycles.
  - Exactly one btn_rise[1] pulse.
  - btn_db[1] stays 1 throughout.
  - No counter wrap artefact.
